// File: rtl/sync_updown_counter_pkg.sv
// Shared definitions for the synchronous up/down modulo-N counter.
//   CNT_WRAP / CNT_SAT : encodings for the SATURATE parameter
//   max_count()        : highest legal count value for a given modulus
package counter_pkg;

    localparam int CNT_WRAP = 0;
    localparam int CNT_SAT  = 1;

    function automatic int max_count(input int modulus);
        return modulus - 1;
    endfunction

endpackage

// File: rtl/sync_updown_counter_if.sv
// Control/status bundle of one counter stage.
//   master : the stage's user (drives T, CARRY_IN, UP, LOAD, D, CLR_OVF)
//   slave  : the counter itself (drives COUNT, TC, CARRY_OUT, OVF)
interface sync_updown_counter_if #(
    parameter int WIDTH = 8
);
    logic             T;
    logic             CARRY_IN;
    logic             UP;
    logic             LOAD;
    logic [WIDTH-1:0] D;
    logic             CLR_OVF;
    logic [WIDTH-1:0] COUNT;
    logic             TC;
    logic             CARRY_OUT;
    logic             OVF;

    modport master (
        output T, CARRY_IN, UP, LOAD, D, CLR_OVF,
        input  COUNT, TC, CARRY_OUT, OVF
    );

    modport slave (
        input  T, CARRY_IN, UP, LOAD, D, CLR_OVF,
        output COUNT, TC, CARRY_OUT, OVF
    );
endinterface

// File: rtl/sync_updown_counter_t_cell.sv
// One counter bit: synchronous T flip-flop with load.
//   clk   : clock (rising edge)
//   rst_n : synchronous active-low clear
//   t     : toggle enable
//   load  : load strobe, wins over t
//   d     : load value
//   q     : registered bit
module sync_t_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic t,
    input  logic load,
    input  logic d,
    output logic q
);
    logic q_d, q_q;

    always_comb begin
        q_d = q_q;
        if (load)
            q_d = d;
        else if (t)
            q_d = ~q_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            q_q <= 1'b0;
        else
            q_q <= q_d;
    end

    assign q = q_q;
endmodule

// File: rtl/sync_updown_counter.sv
// Synchronous up/down modulo-MODULUS counter built from WIDTH T-cells.
//   CLK   : clock, all state changes on the rising edge
//   RST_N : synchronous active-low reset (COUNT=0, OVF=0)
//   bus   : slave side of the control/status bundle
//           inputs  T, CARRY_IN, UP, LOAD, D, CLR_OVF
//           outputs COUNT (reg), TC (comb), CARRY_OUT (comb), OVF (reg, sticky)
// SATURATE selects wrap (CNT_WRAP) or hold-and-flag (CNT_SAT) at the range ends.
module sync_updown_counter #(
    parameter int WIDTH    = 8,
    parameter int MODULUS  = 2**WIDTH,
    parameter int SATURATE = 0
) (
    input  logic CLK,
    input  logic RST_N,
    sync_updown_counter_if.slave bus
);
    import counter_pkg::*;

    generate
        if (MODULUS < 2 || MODULUS > 2**WIDTH) begin : g_bad_modulus
            $error("sync_updown_counter: MODULUS %0d out of range 2..2**WIDTH", MODULUS);
        end
    endgenerate

    // One extra bit so D > MAX_CNT and the end-of-range tests never rely on
    // natural WIDTH-bit rollover when MODULUS < 2**WIDTH.
    localparam logic [WIDTH:0] MAX_CNT = (WIDTH+1)'(max_count(MODULUS));
    localparam logic [WIDTH:0] ONE     = (WIDTH+1)'(1);

    logic [WIDTH-1:0] count_q, count_d, toggle;
    logic [WIDTH:0]   cnt_ext, load_ext, next_ext;
    logic             ovf_d, ovf_q;
    logic             step, at_max, at_zero, tc;
    logic             unused_msb;

    assign cnt_ext  = {1'b0, count_q};
    assign load_ext = {1'b0, bus.D};
    assign at_max   = (cnt_ext == MAX_CNT);
    assign at_zero  = (count_q == '0);
    assign step     = bus.T && bus.CARRY_IN && !bus.LOAD;

    always_comb begin
        next_ext = cnt_ext;
        ovf_d    = ovf_q;
        // Clear first so any set below in the same cycle takes precedence.
        if (bus.CLR_OVF)
            ovf_d = 1'b0;
        if (bus.LOAD) begin
            if (load_ext > MAX_CNT) begin
                next_ext = MAX_CNT;
                ovf_d    = 1'b1;
            end else begin
                next_ext = load_ext;
            end
        end else if (step) begin
            if (bus.UP) begin
                if (!at_max)                    next_ext = cnt_ext + ONE;
                else if (SATURATE == CNT_SAT)   ovf_d    = 1'b1;
                else                            next_ext = '0;
            end else begin
                if (!at_zero)                   next_ext = cnt_ext - ONE;
                else if (SATURATE == CNT_SAT)   ovf_d    = 1'b1;
                else                            next_ext = MAX_CNT;
            end
        end
    end

    assign count_d    = next_ext[WIDTH-1:0];
    assign unused_msb = next_ext[WIDTH];
    // Bits that change toggle; in load cycles the cells take count_d directly.
    assign toggle     = count_d ^ count_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sync_t_cell u_cell (
            .clk   (CLK),
            .rst_n (RST_N),
            .t     (toggle[i]),
            .load  (bus.LOAD),
            .d     (count_d[i]),
            .q     (count_q[i])
        );
    end

    always_ff @(posedge CLK) begin
        if (!RST_N)
            ovf_q <= 1'b0;
        else
            ovf_q <= ovf_d;
    end

    assign tc            = bus.UP ? at_max : at_zero;
    assign bus.COUNT     = count_q;
    assign bus.TC        = tc;
    assign bus.CARRY_OUT = tc && step;
    assign bus.OVF       = ovf_q;
endmodule

// File: tb/tb_sync_updown_counter.sv
module tb_sync_updown_counter;
    logic CLK = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 CLK = ~CLK;

    sync_updown_counter_if #(.WIDTH(8)) ifa ();
    sync_updown_counter_if #(.WIDTH(8)) ifw ();
    sync_updown_counter_if #(.WIDTH(8)) ifs ();
    sync_updown_counter_if #(.WIDTH(4)) iflo ();
    sync_updown_counter_if #(.WIDTH(4)) ifh ();

    sync_updown_counter #(.WIDTH(8), .MODULUS(256), .SATURATE(0)) u_a (.CLK(CLK), .RST_N(rst_n), .bus(ifa));
    sync_updown_counter #(.WIDTH(8), .MODULUS(10),  .SATURATE(0)) u_w (.CLK(CLK), .RST_N(rst_n), .bus(ifw));
    sync_updown_counter #(.WIDTH(8), .MODULUS(10),  .SATURATE(1)) u_s (.CLK(CLK), .RST_N(rst_n), .bus(ifs));
    sync_updown_counter #(.WIDTH(4), .MODULUS(16),  .SATURATE(0)) u_lo (.CLK(CLK), .RST_N(rst_n), .bus(iflo));
    sync_updown_counter #(.WIDTH(4), .MODULUS(16),  .SATURATE(0)) u_hi (.CLK(CLK), .RST_N(rst_n), .bus(ifh));

    assign ifh.CARRY_IN = iflo.CARRY_OUT;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        ifa.UP = 1'b0;
        #1;
        total++; if (ifa.COUNT !== 8'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", ifa.COUNT); end
        total++; if (ifa.OVF !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %0b want 0", ifa.OVF); end
        total++; if (ifa.TC !== 1'b1) begin bad++; $display("FAIL reset_tc_down: got %0b want 1", ifa.TC); end
        ifa.UP = 1'b1;
        #1;
        total++; if (ifa.TC !== 1'b0) begin bad++; $display("FAIL reset_tc_up: got %0b want 0", ifa.TC); end
        total++; if (ifs.COUNT !== 8'd0) begin bad++; $display("FAIL reset_count_s: got %0d want 0", ifs.COUNT); end
    endtask

    task automatic test_count_full;
        ifa.UP = 1'b1;
        ifa.T  = 1'b1;
        for (int i = 0; i < 256; i++) begin
            #1;
            total++; if (ifa.COUNT !== 8'(i)) begin bad++; $display("FAIL full_count: got %0d want %0d", ifa.COUNT, i); end
            total++; if (ifa.CARRY_OUT !== (i == 255)) begin bad++; $display("FAIL full_carry at %0d: got %0b want %0b", i, ifa.CARRY_OUT, (i == 255)); end
            tick();
        end
        total++; if (ifa.COUNT !== 8'd0) begin bad++; $display("FAIL full_wrap: got %0d want 0", ifa.COUNT); end
        ifa.T = 1'b0;
    endtask

    task automatic test_wrap;
        ifw.LOAD = 1'b1; ifw.D = 8'd9;
        tick();
        ifw.LOAD = 1'b0;
        total++; if (ifw.COUNT !== 8'd9) begin bad++; $display("FAIL wrap_load9: got %0d want 9", ifw.COUNT); end
        ifw.UP = 1'b1; ifw.T = 1'b1;
        #1;
        total++; if (ifw.TC !== 1'b1) begin bad++; $display("FAIL wrap_tc_up: got %0b want 1", ifw.TC); end
        total++; if (ifw.CARRY_OUT !== 1'b1) begin bad++; $display("FAIL wrap_carry_up: got %0b want 1", ifw.CARRY_OUT); end
        tick();
        total++; if (ifw.COUNT !== 8'd0) begin bad++; $display("FAIL wrap_up: got %0d want 0", ifw.COUNT); end
        total++; if (ifw.CARRY_OUT !== 1'b0) begin bad++; $display("FAIL wrap_carry_idle: got %0b want 0", ifw.CARRY_OUT); end
        ifw.UP = 1'b0;
        #1;
        total++; if (ifw.CARRY_OUT !== 1'b1) begin bad++; $display("FAIL wrap_carry_down: got %0b want 1", ifw.CARRY_OUT); end
        tick();
        total++; if (ifw.COUNT !== 8'd9) begin bad++; $display("FAIL wrap_down: got %0d want 9", ifw.COUNT); end
        total++; if (ifw.OVF !== 1'b0) begin bad++; $display("FAIL wrap_ovf: got %0b want 0", ifw.OVF); end
        ifw.T = 1'b0;
    endtask

    task automatic test_saturate;
        ifs.LOAD = 1'b1; ifs.D = 8'd9;
        tick();
        ifs.LOAD = 1'b0; ifs.UP = 1'b1; ifs.T = 1'b1;
        tick();
        total++; if (ifs.COUNT !== 8'd9) begin bad++; $display("FAIL sat_up_hold: got %0d want 9", ifs.COUNT); end
        total++; if (ifs.OVF !== 1'b1) begin bad++; $display("FAIL sat_up_ovf: got %0b want 1", ifs.OVF); end
        ifs.T = 1'b0; ifs.CLR_OVF = 1'b1;
        tick();
        ifs.CLR_OVF = 1'b0;
        total++; if (ifs.OVF !== 1'b0) begin bad++; $display("FAIL sat_clr: got %0b want 0", ifs.OVF); end
        total++; if (ifs.COUNT !== 8'd9) begin bad++; $display("FAIL sat_clr_count: got %0d want 9", ifs.COUNT); end
        ifs.LOAD = 1'b1; ifs.D = 8'd0;
        tick();
        ifs.LOAD = 1'b0; ifs.UP = 1'b0; ifs.T = 1'b1;
        tick();
        total++; if (ifs.COUNT !== 8'd0) begin bad++; $display("FAIL sat_down_hold: got %0d want 0", ifs.COUNT); end
        total++; if (ifs.OVF !== 1'b1) begin bad++; $display("FAIL sat_down_ovf: got %0b want 1", ifs.OVF); end
        ifs.CLR_OVF = 1'b1;
        tick();
        total++; if (ifs.OVF !== 1'b1) begin bad++; $display("FAIL sat_set_wins: got %0b want 1", ifs.OVF); end
        ifs.T = 1'b0;
        tick();
        total++; if (ifs.OVF !== 1'b0) begin bad++; $display("FAIL sat_clr2: got %0b want 0", ifs.OVF); end
        ifs.CLR_OVF = 1'b0;
    endtask

    task automatic test_load;
        ifw.LOAD = 1'b1; ifw.D = 8'd200;
        tick();
        total++; if (ifw.COUNT !== 8'd9) begin bad++; $display("FAIL load_clamp: got %0d want 9", ifw.COUNT); end
        total++; if (ifw.OVF !== 1'b1) begin bad++; $display("FAIL load_clamp_ovf: got %0b want 1", ifw.OVF); end
        ifw.D = 8'd5; ifw.T = 1'b1; ifw.UP = 1'b1;
        #1;
        total++; if (ifw.CARRY_OUT !== 1'b0) begin bad++; $display("FAIL load_carry_forced: got %0b want 0", ifw.CARRY_OUT); end
        tick();
        ifw.LOAD = 1'b0;
        total++; if (ifw.COUNT !== 8'd5) begin bad++; $display("FAIL load_over_count: got %0d want 5", ifw.COUNT); end
        ifw.CARRY_IN = 1'b0;
        tick();
        total++; if (ifw.COUNT !== 8'd5) begin bad++; $display("FAIL hold_cin0: got %0d want 5", ifw.COUNT); end
        ifw.CARRY_IN = 1'b1; ifw.T = 1'b0;
        tick();
        total++; if (ifw.COUNT !== 8'd5) begin bad++; $display("FAIL hold_t0: got %0d want 5", ifw.COUNT); end
        total++; if (ifw.OVF !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %0b want 1", ifw.OVF); end
    endtask

    task automatic test_reset_mid;
        ifa.UP = 1'b1; ifa.T = 1'b1;
        repeat (37) tick();
        total++; if (ifa.COUNT !== 8'd37) begin bad++; $display("FAIL mid_count37: got %0d want 37", ifa.COUNT); end
        rst_n = 1'b0; ifa.LOAD = 1'b1; ifa.D = 8'd100;
        tick();
        total++; if (ifa.COUNT !== 8'd0) begin bad++; $display("FAIL mid_reset_count: got %0d want 0", ifa.COUNT); end
        total++; if (ifa.OVF !== 1'b0) begin bad++; $display("FAIL mid_reset_ovf: got %0b want 0", ifa.OVF); end
        total++; if (ifw.OVF !== 1'b0) begin bad++; $display("FAIL mid_reset_ovf_w: got %0b want 0", ifw.OVF); end
        rst_n = 1'b1; ifa.LOAD = 1'b0;
        tick();
        tick();
        total++; if (ifa.COUNT !== 8'd2) begin bad++; $display("FAIL mid_resume: got %0d want 2", ifa.COUNT); end
        ifa.T = 1'b0;
    endtask

    task automatic test_cascade;
        iflo.UP = 1'b1; ifh.UP = 1'b1;
        iflo.LOAD = 1'b1; ifh.LOAD = 1'b1; iflo.D = 4'hF; ifh.D = 4'h0;
        tick();
        iflo.LOAD = 1'b0; ifh.LOAD = 1'b0;
        total++; if ({ifh.COUNT, iflo.COUNT} !== 8'h0F) begin bad++; $display("FAIL casc_load0f: got %0h want 0f", {ifh.COUNT, iflo.COUNT}); end
        iflo.T = 1'b1; ifh.T = 1'b1;
        #1;
        total++; if (iflo.CARRY_OUT !== 1'b1) begin bad++; $display("FAIL casc_lo_carry: got %0b want 1", iflo.CARRY_OUT); end
        tick();
        total++; if ({ifh.COUNT, iflo.COUNT} !== 8'h10) begin bad++; $display("FAIL casc_0f_10: got %0h want 10", {ifh.COUNT, iflo.COUNT}); end
        tick();
        total++; if ({ifh.COUNT, iflo.COUNT} !== 8'h11) begin bad++; $display("FAIL casc_10_11: got %0h want 11", {ifh.COUNT, iflo.COUNT}); end
        iflo.T = 1'b0;
        iflo.LOAD = 1'b1; ifh.LOAD = 1'b1; iflo.D = 4'hF; ifh.D = 4'hF;
        tick();
        iflo.LOAD = 1'b0; ifh.LOAD = 1'b0; iflo.T = 1'b1;
        #1;
        total++; if (ifh.CARRY_OUT !== 1'b1) begin bad++; $display("FAIL casc_hi_carry: got %0b want 1", ifh.CARRY_OUT); end
        tick();
        total++; if ({ifh.COUNT, iflo.COUNT} !== 8'h00) begin bad++; $display("FAIL casc_ff_00: got %0h want 00", {ifh.COUNT, iflo.COUNT}); end
        iflo.T = 1'b0; ifh.T = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        ifa.T = 0;  ifa.CARRY_IN = 1;  ifa.UP = 1;  ifa.LOAD = 0;  ifa.D = '0;  ifa.CLR_OVF = 0;
        ifw.T = 0;  ifw.CARRY_IN = 1;  ifw.UP = 1;  ifw.LOAD = 0;  ifw.D = '0;  ifw.CLR_OVF = 0;
        ifs.T = 0;  ifs.CARRY_IN = 1;  ifs.UP = 1;  ifs.LOAD = 0;  ifs.D = '0;  ifs.CLR_OVF = 0;
        iflo.T = 0; iflo.CARRY_IN = 1; iflo.UP = 1; iflo.LOAD = 0; iflo.D = '0; iflo.CLR_OVF = 0;
        ifh.T = 0;  ifh.UP = 1;  ifh.LOAD = 0;  ifh.D = '0;  ifh.CLR_OVF = 0;
        #2;
        test_reset();
        test_count_full();
        test_wrap();
        test_saturate();
        test_load();
        test_reset_mid();
        test_cascade();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
